// File: rtl/signal_capture_sched_if.sv
// Control, mux-select and BRAM write-port bundle for signal_capture_sched.
// slave = the scheduler, master = whatever drives start/abort/mask and consumes the writes.
interface signal_capture_sched_if #(
  parameter int NB_DATA = 8,
  parameter int NB_SEL  = 2,
  parameter int NB_CNT  = 8
);
  localparam int NB_ADDR = NB_SEL + NB_CNT;
  localparam int NCH     = 1 << NB_SEL;

  logic                      i_start;
  logic                      i_abort;
  logic [NCH-1:0]            i_mask;
  logic signed [NB_DATA-1:0] i_signal;
  logic [NB_SEL-1:0]         o_sel;
  logic                      o_bram_we;
  logic [NB_ADDR-1:0]        o_bram_addr;
  logic [NB_DATA-1:0]        o_bram_data;
  logic                      o_busy;
  logic                      o_done;

  modport slave (
    input  i_start, i_abort, i_mask, i_signal,
    output o_sel, o_bram_we, o_bram_addr, o_bram_data, o_busy, o_done
  );

  modport master (
    output i_start, i_abort, i_mask, i_signal,
    input  o_sel, o_bram_we, o_bram_addr, o_bram_data, o_busy, o_done
  );
endinterface

// File: rtl/signal_capture_sched.sv
// Steps the mux select through enabled channels, settles, then writes 2^NB_CNT samples per channel to BRAM.
// Optional SIGNAL_CAPTURE_SCHED_LOOP_EN: restart from the lowest channel while i_start stays high.
module signal_capture_sched #(
  parameter int NB_DATA    = 8,
  parameter int NB_SEL     = 2,
  parameter int NB_CNT     = 8,
  parameter int SETTLE_CYC = 16
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  signal_capture_sched_if.slave bus,
  output logic [2:0]            o_state
);
  localparam int NB_ADDR = NB_SEL + NB_CNT;
  localparam int NCH     = 1 << NB_SEL;
  localparam int NB_SET  = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [NB_SET-1:0] SETTLE_LAST = NB_SET'(SETTLE_CYC - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETTLE  = 3'd1,
    CAPTURE = 3'd2,
    NEXT    = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t             r_state, w_state;
  logic [NCH-1:0]     r_mask, w_mask;
  logic [NB_SEL-1:0]  r_sel, w_sel;
  logic [NB_SET-1:0]  r_settle, w_settle;
  logic [NB_CNT-1:0]  r_idx, w_idx;
  logic               r_we, w_we;
  logic [NB_ADDR-1:0] r_addr, w_addr;
  logic [NB_DATA-1:0] r_data, w_data;
  logic               r_busy, w_busy;
  logic               r_done, w_done;
  logic [NB_SEL-1:0]  w_low_in, w_low_mask, w_above;
  logic               w_found;

  // Channel search: lowest set bit of the live and latched masks, and the
  // lowest latched bit strictly above the current select (no wrap).
  always_comb begin
    w_low_in   = '0;
    w_low_mask = '0;
    w_above    = r_sel;
    w_found    = 1'b0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (bus.i_mask[i]) w_low_in = NB_SEL'(i);
      if (r_mask[i]) w_low_mask = NB_SEL'(i);
      if (r_mask[i] && (i > int'(r_sel))) begin
        w_above = NB_SEL'(i);
        w_found = 1'b1;
      end
    end
  end

  always_comb begin
    w_state  = r_state;
    w_mask   = r_mask;
    w_sel    = r_sel;
    w_settle = r_settle;
    w_idx    = r_idx;
    w_we     = 1'b0;
    w_addr   = r_addr;
    w_data   = r_data;
    case (r_state)
      IDLE: begin
        if (bus.i_start && !bus.i_abort && (bus.i_mask != '0)) begin
          w_state  = SETTLE;
          w_mask   = bus.i_mask;
          w_sel    = w_low_in;
          w_settle = '0;
        end
      end
      SETTLE: begin
        if (r_settle == SETTLE_LAST) begin
          w_state = CAPTURE;
          w_idx   = '0;
        end else begin
          w_settle = r_settle + 1'b1;
        end
      end
      CAPTURE: begin
        w_we   = 1'b1;
        w_addr = {r_sel, r_idx};
        w_data = bus.i_signal;
        w_idx  = r_idx + 1'b1;
        if (&r_idx) w_state = NEXT;
      end
      NEXT: begin
        if (w_found) begin
          w_state  = SETTLE;
          w_sel    = w_above;
          w_settle = '0;
        end else begin
`ifdef SIGNAL_CAPTURE_SCHED_LOOP_EN
          if (bus.i_start) begin
            w_state  = SETTLE;
            w_sel    = w_low_mask;
            w_settle = '0;
          end else begin
            w_state = DONE;
          end
`else
          w_state = DONE;
`endif
        end
      end
      DONE:    w_state = IDLE;
      default: w_state = IDLE;
    endcase
    // Abort overrides everything: drop the write, keep the select, skip DONE.
    if (bus.i_abort && (r_state != IDLE)) begin
      w_state = IDLE;
      w_we    = 1'b0;
      w_sel   = r_sel;
    end
  end

  assign w_busy = (w_state == SETTLE) || (w_state == CAPTURE) || (w_state == NEXT);
  assign w_done = (w_state == DONE);

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) r_state <= IDLE;
    else          r_state <= w_state;
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_mask   <= '0;
      r_sel    <= '0;
      r_settle <= '0;
      r_idx    <= '0;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_data   <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_mask   <= w_mask;
      r_sel    <= w_sel;
      r_settle <= w_settle;
      r_idx    <= w_idx;
      r_we     <= w_we;
      r_addr   <= w_addr;
      r_data   <= w_data;
      r_busy   <= w_busy;
      r_done   <= w_done;
    end
  end

  assign bus.o_sel       = r_sel;
  assign bus.o_bram_we   = r_we;
  assign bus.o_bram_addr = r_addr;
  assign bus.o_bram_data = r_data;
  assign bus.o_busy      = r_busy;
  assign bus.o_done      = r_done;
  assign o_state         = r_state;
endmodule

// File: doc/signal_capture_sched.md
# signal_capture_sched

Capture scheduler for the signal generator / FIR / BRAM chain. It steps the signal multiplexer select through a set of enabled channels. After each switch it waits a fixed number of cycles so the mux and filter output can settle, then writes a block of 2^NB_CNT consecutive samples per channel into BRAM at address {sel, index}. It sits between the user control (start/abort/mask) and the mux select input and BRAM write port.

## Interface
- NB_DATA, 8, sample width (signed)
- NB_SEL, 2, mux select width; 2^NB_SEL channels
- NB_CNT, 8, log2 of samples captured per channel
- SETTLE_CYC, 16, settle cycles after each select change (>=1)
- NB_ADDR, NB_SEL+NB_CNT, BRAM address width (derived, not overridden)

- i_clock  in  1  system clock, rising edge
- i_reset  in  1  asynchronous, active-low reset
- i_start  in  1  level; sampled only in IDLE
- i_abort  in  1  synchronous abort, any state
- i_mask  in  2^NB_SEL  channel enable, bit n = channel n
- i_signal  in  NB_DATA  mux/filter output, signed
- o_sel  out  NB_SEL  mux select
- o_bram_we  out  1  BRAM write enable
- o_bram_addr  out  NB_ADDR  {o_sel, sample index}
- o_bram_data  out  NB_DATA  captured sample
- o_busy  out  1  sequence in progress
- o_done  out  1  one-cycle completion pulse

## Operation
- States: IDLE, SETTLE, CAPTURE, NEXT, DONE. All outputs are registered.
- **IDLE**
  - If i_start=1 and i_mask!=0: latch i_mask into r_mask, set o_sel to the lowest set bit, clear the settle counter, go to SETTLE.
  - If i_mask==0: i_start is ignored and the block stays in IDLE.
- **SETTLE**: count SETTLE_CYC cycles. No writes. Then clear the sample counter and go to CAPTURE.
- **CAPTURE**: lasts 2^NB_CNT cycles. In cycle k (k=0..2^NB_CNT-1) i_signal is sampled. On the next edge: o_bram_we=1, o_bram_addr={o_sel,k}, o_bram_data=i_signal. After k=2^NB_CNT-1, go to NEXT.
- **NEXT** (one cycle): search r_mask for the next set bit strictly above o_sel.
  - If found: o_sel takes that value, go to SETTLE.
  - If none: go to DONE.
  - The search never wraps to lower channels.
- **DONE** (one cycle): o_done=1, then go to IDLE.
- o_busy=1 in SETTLE, CAPTURE and NEXT; 0 in IDLE and DONE.
- Mid-sequence changes to i_mask have no effect. Only the latched r_mask is used.
- i_abort=1 in any non-IDLE state: next state is IDLE; o_bram_we=0 next cycle; o_done is not pulsed; o_sel holds its value.
- If i_abort and i_start are both high in IDLE, abort wins and the block stays in IDLE.
- Sample counter is NB_CNT bits and wraps naturally. The CAPTURE exit is decoded on all-ones.
- Asynchronous reset (i_reset=0) mid-operation forces IDLE and all outputs to 0 immediately.

## Timing
- Reset values: o_sel=0, o_bram_we=0, o_bram_addr=0, o_bram_data=0, o_busy=0, o_done=0.
- Start latency: i_start high at edge t gives SETTLE, o_sel valid and o_busy=1 from edge t+1.
- Per channel: SETTLE_CYC + 2^NB_CNT + 1 cycles (SETTLE + CAPTURE + NEXT).
- Write latency: 1 cycle from sample to o_bram_we/addr/data. The last write of a channel is presented during NEXT.
- o_sel changes only on entry to SETTLE. It is stable for at least SETTLE_CYC cycles before any capture.
- Total pass for m enabled channels: m*(SETTLE_CYC + 2^NB_CNT + 1) cycles in busy states, then 1 DONE cycle.

## Configuration
- Macro: SIGNAL_CAPTURE_SCHED_LOOP_EN.
- Defined: in NEXT with no higher channel, if i_start=1 the block restarts at the lowest set bit of r_mask. It enters SETTLE directly; no DONE pulse, o_busy stays 1. If i_start=0, it goes to DONE as usual.
- Undefined: single-shot. NEXT with no higher channel always goes to DONE, whatever the level of i_start.

## Test plan
Bench settings for all scenarios: NB_CNT=3, SETTLE_CYC=4, NB_SEL=2, NB_ADDR=5.

1. **Reset:** assert i_reset=0 mid-CAPTURE.
   - All outputs go to 0 asynchronously.
   - After release, the block idles until i_start.
2. **Two channels:** i_mask=4'b0101, one-cycle i_start.
   - Writes to addresses 0..7 with o_sel=0, then 16..23 with o_sel=2.
   - o_busy high for 26 cycles; o_done pulses once.
   - i_signal ramp is reproduced exactly in o_bram_data.
3. **Empty mask:** i_mask=0, i_start=1 for 10 cycles.
   - Block stays in IDLE; o_busy=0; no writes.
4. **Abort:** i_mask=4'b1111; i_abort=1 at the 3rd write of channel 1.
   - o_bram_we=0 on the next cycle; state IDLE; no o_done.
   - A following i_start restarts from channel 0.
5. **Mask change mid-run:** i_mask changes from 4'b1000 to 4'b0001 one cycle after start.
   - Only channel 3 is captured, at addresses 24..31.
6. **Loop mode (SIGNAL_CAPTURE_SCHED_LOOP_EN defined):** i_start held high, i_mask=4'b0010.
   - Channel 1 is recaptured back-to-back with no o_done.
   - Drop i_start: the current pass finishes, then a single o_done pulse.
